i2s_master_tx: RTL and testbench
================================

Name: i2s_master_tx

Overview:
- I2S transmitter that is itself the bus master: generates BCLK and LRCK from the system clock and serialises stereo samples onto the DAC data line.
- Used with codecs or DACs configured as I2S slaves, the opposite clocking arrangement from the WM8978 master-mode path.
- Stereo samples arrive through a valid/ready handshake into a one-frame holding buffer.
- Sits between the audio sample source (FIFO, tone generator or loopback) and the board's audio pins.

Parameters:
- CLK_DIV, 8: clk cycles per BCLK half-period; minimum 1. BCLK = f_clk/(2*CLK_DIV); Fs = f_clk/(128*CLK_DIV). At 50 MHz with the default, Fs = 48.828 kHz.
- WL, 32: sample word length, one of 16, 24 or 32; each slot is always 32 BCLKs wide.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_l  input  WL  left sample, two's complement.
- in_r  input  WL  right sample.
- in_valid  input  1  source has a stereo pair on in_l/in_r.
- in_ready  output  1  holding buffer empty; transfer occurs when in_valid & in_ready at a clk edge.
- aud_bclk  output  1  bit clock, 50% duty.
- aud_lrc  output  1  word select; 0 = left, 1 = right.
- aud_dacdat  output  1  serial data, MSB first, I2S one-BCLK delay.
- tx_done  output  1  one-clk pulse when a frame is loaded into the shifter.
- underrun  output  1  one-clk pulse when a frame is loaded with the buffer empty.

Behaviour:
- Reset values:
  - aud_bclk = 0, aud_lrc = 0, aud_dacdat = 0, tx_done = 0, underrun = 0.
  - div_cnt = 0, bit_cnt = 0, shifter = 0, buffer empty.
  - in_ready = 0 while rst is high.
  - Reset asserted mid-frame aborts the frame immediately and discards buffer contents.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At terminal count: div_cnt ← 0 and aud_bclk toggles.
  - A "fall tick" is a terminal count while aud_bclk = 1.
  - First BCLK rising edge is registered CLK_DIV cycles after rst deasserts; first fall tick comes at 2*CLK_DIV.
- Bit counter: 6-bit bit_cnt increments on every fall tick, wrapping 63→0. At the same edge, aud_lrc ← new bit_cnt[5]. Positions 0-31 are left, 32-63 are right.
- Data changes only on fall ticks, so data is stable at BCLK rise for the slave.
- Frame load, on the fall tick where bit_cnt becomes 1:
  - frame = {in_l_buf, (32-WL)'b0, in_r_buf, (32-WL)'b0}, or all zeros if the buffer is empty.
  - aud_dacdat ← frame[63] (left MSB).
  - shifter ← frame << 1.
  - tx_done pulses.
  - Buffer is marked empty, or underrun pulses if it was already empty.
- On all other fall ticks: aud_dacdat ← shifter[63] and shifter ← shifter << 1.
- Consequences of the one-BCLK delay:
  - Position 0 carries the final bit of the previous frame's right slot.
  - The right MSB appears at position 33.
- Handshake:
  - in_ready = ~buf_full & ~rst.
  - Accept latches in_l/in_r and sets buf_full; in_ready drops the next cycle.
  - The load edge clears buf_full. in_ready rises the following cycle. An accept cannot coincide with the load because in_ready was low.
  - in_valid while in_ready = 0 is ignored. The source must hold its data; nothing is dropped silently.
- Latency: a pair accepted before the load edge of frame N appears in frame N. The left MSB is on aud_dacdat at the first fall tick with bit_cnt = 1 after acceptance.
- Arithmetic: no sign extension or rounding; samples pass bit-exact, zero padded on the LSB side.

Test Plan:
- Reset: hold rst for 5 clk → all outputs 0 and in_ready = 0. After release with CLK_DIV = 2: first aud_bclk rise at cycle 2, first fall tick at cycle 4, aud_lrc rises after 32 fall ticks.
- Single frame, WL = 32, CLK_DIV = 2: L = 32'hA5A5_0001, R = 32'h8000_00FF sent before the first load.
  - Sample aud_dacdat at BCLK rises for positions 1-32 → A5A50001, MSB first.
  - Positions 33-63 plus next position 0 → 800000FF.
  - tx_done pulses once.
- Underrun: no in_valid for two frames.
  - aud_dacdat stays 0 throughout.
  - underrun pulses exactly once per frame, at each bit_cnt→1 edge.
  - tx_done also pulses.
- Backpressure: in_valid held high with an incrementing pattern.
  - in_ready drops after each accept and re-rises one clk after each load.
  - Exactly one pair is consumed per 128*CLK_DIV clk; no sample is skipped or duplicated.
- WL = 16: L = 16'h8001, R = 16'h7FFE.
  - Left slot carries 8001 followed by 16 zeros.
  - Right slot carries 7FFE followed by zeros.
  - Slot timing is identical to WL = 32.
- Reset mid-frame: assert rst at bit_cnt = 40 with the buffer full.
  - All outputs return to reset values the next clk.
  - After release the buffered pair is not transmitted; the first frame underruns.

Source files
------------

// File: rtl/i2s_master_tx.sv
// I2S bus-master transmitter: divides clk down to BCLK/LRCK and shifts a
// buffered stereo pair out MSB first with the standard one-BCLK data delay.
module i2s_master_tx #(
    parameter int CLK_DIV = 8,
    parameter int WL      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WL-1:0] in_l,
    input  logic [WL-1:0] in_r,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          aud_bclk,
    output logic          aud_lrc,
    output logic          aud_dacdat,
    output logic          tx_done,
    output logic          underrun
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic          bclk_q, lrc_q, dat_q, tx_done_q, underrun_q, buf_full_q;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [63:0]   shifter_q, frame;
    logic [WL-1:0] l_buf_q, r_buf_q;
    logic [31:0]   l_slot, r_slot;
    logic          tc, fall, load, accept;

    always_comb begin
        tc        = (div_cnt_q == DIV_LAST);
        fall      = tc & bclk_q;
        bit_cnt_d = bit_cnt_q + 6'd1;
        load      = fall & (bit_cnt_d == 6'd1);
        accept    = in_valid & in_ready;
        // Samples sit in the top of each 32-bit slot; unused LSBs are zero.
        l_slot    = 32'(l_buf_q) << (32 - WL);
        r_slot    = 32'(r_buf_q) << (32 - WL);
        frame     = buf_full_q ? {l_slot, r_slot} : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            lrc_q      <= 1'b0;
            dat_q      <= 1'b0;
            bit_cnt_q  <= 6'd0;
            shifter_q  <= 64'd0;
            tx_done_q  <= 1'b0;
            underrun_q <= 1'b0;
            buf_full_q <= 1'b0;
            l_buf_q    <= '0;
            r_buf_q    <= '0;
        end else begin
            tx_done_q  <= 1'b0;
            underrun_q <= 1'b0;
            div_cnt_q  <= tc ? '0 : DW'(div_cnt_q + 1'b1);
            if (tc) bclk_q <= ~bclk_q;
            // Everything on the data side moves on the BCLK falling edge only.
            if (fall) begin
                bit_cnt_q <= bit_cnt_d;
                lrc_q     <= bit_cnt_d[5];
                if (load) begin
                    dat_q      <= frame[63];
                    shifter_q  <= frame << 1;
                    tx_done_q  <= 1'b1;
                    underrun_q <= ~buf_full_q;
                end else begin
                    dat_q     <= shifter_q[63];
                    shifter_q <= shifter_q << 1;
                end
            end
            if (load) buf_full_q <= 1'b0;
            // An accept only happens while empty, so it never fights a load that clears.
            if (accept) begin
                buf_full_q <= 1'b1;
                l_buf_q    <= in_l;
                r_buf_q    <= in_r;
            end
        end
    end

    assign in_ready   = ~buf_full_q & ~rst;
    assign aud_bclk   = bclk_q;
    assign aud_lrc    = lrc_q;
    assign aud_dacdat = dat_q;
    assign tx_done    = tx_done_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: WL=32 and WL=16 instances at CLK_DIV=2 run side by side
// against a time-arithmetic reference model plus a per-frame serial word capture.
module tb_i2s_master_tx;
    localparam int D = 2;

    logic        clk = 1'b0, rst = 1'b1, vld = 1'b0;
    logic [31:0] l32 = '0, r32 = '0;
    logic [15:0] l16 = '0, r16 = '0;
    logic        rdy32, bclk32, lrc32, dat32, txd32, und32;
    logic        rdy16, bclk16, lrc16, dat16, txd16, und16;

    always #5 clk = ~clk;

    i2s_master_tx #(.CLK_DIV(D), .WL(32)) dut32 (
        .clk(clk), .rst(rst), .in_l(l32), .in_r(r32), .in_valid(vld), .in_ready(rdy32),
        .aud_bclk(bclk32), .aud_lrc(lrc32), .aud_dacdat(dat32), .tx_done(txd32), .underrun(und32));
    i2s_master_tx #(.CLK_DIV(D), .WL(16)) dut16 (
        .clk(clk), .rst(rst), .in_l(l16), .in_r(r16), .in_valid(vld), .in_ready(rdy16),
        .aud_bclk(bclk16), .aud_lrc(lrc16), .aud_dacdat(dat16), .tx_done(txd16), .underrun(und16));

    int          vectors = 0, miscompares = 0;
    int          t = 0;
    bit          mfull, acc_last, reached;
    bit          e_bclk, e_lrc, e_txd, e_und, e_dat0, e_dat1;
    logic [31:0] ml0, mr0, ml1, mr1;
    logic [63:0] cur0, cur1, cap0, cap1;
    logic [63:0] sentq0[$], sentq1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at t=%0d", tag, obs, exp, t);
        end
    endtask

    // Model works from elapsed clk count: BCLK phase = t/D, bit position = t/(2D) mod 64.
    task automatic model_edge();
        int p;
        if (rst) begin
            t = 0; mfull = 0; acc_last = 0;
            cur0 = '0; cur1 = '0; cap0 = '0; cap1 = '0;
            e_bclk = 0; e_lrc = 0; e_txd = 0; e_und = 0; e_dat0 = 0; e_dat1 = 0;
            sentq0.delete(); sentq1.delete();
        end else begin
            acc_last = vld && !mfull;
            t++;
            e_txd = 0; e_und = 0;
            e_bclk = ((t / D) % 2) == 1;
            if (t % (2*D) == 0) begin
                p = (t / (2*D)) % 64;
                e_lrc = (p >= 32);
                if (p == 1) begin
                    e_txd = 1;
                    e_und = !mfull;
                    cur0 = mfull ? {ml0, mr0} : 64'd0;
                    cur1 = mfull ? {ml1, mr1} : 64'd0;
                    sentq0.push_back(cur0);
                    sentq1.push_back(cur1);
                    mfull = 0;
                end
                e_dat0 = cur0[(64 - p) % 64];
                e_dat1 = cur1[(64 - p) % 64];
            end
            if (acc_last) begin
                mfull = 1;
                ml0 = l32; mr0 = r32;
                ml1 = {l16, 16'h0000}; mr1 = {r16, 16'h0000};
            end
        end
    endtask

    task automatic check_outputs();
        int k, pos;
        chk("ready32", 64'(rdy32), 64'(!mfull && !rst));
        chk("ready16", 64'(rdy16), 64'(!mfull && !rst));
        chk("bclk32", 64'(bclk32), 64'(e_bclk));
        chk("bclk16", 64'(bclk16), 64'(e_bclk));
        chk("lrc32", 64'(lrc32), 64'(e_lrc));
        chk("lrc16", 64'(lrc16), 64'(e_lrc));
        chk("dat32", 64'(dat32), 64'(e_dat0));
        chk("dat16", 64'(dat16), 64'(e_dat1));
        chk("txdone32", 64'(txd32), 64'(e_txd));
        chk("txdone16", 64'(txd16), 64'(e_txd));
        chk("underrun32", 64'(und32), 64'(e_und));
        chk("underrun16", 64'(und16), 64'(e_und));
        // Slave view: sample data at each BCLK rise; positions 1..63 then next 0 form a frame.
        if (!rst && t > 0 && (t % (2*D) == D)) begin
            k = t / (2*D);
            pos = k % 64;
            cap0 = {cap0[62:0], dat32};
            cap1 = {cap1[62:0], dat16};
            if (pos == 0 && k > 0) begin
                if (sentq0.size() > 0) chk("frame32", cap0, sentq0.pop_front());
                if (sentq1.size() > 0) chk("frame16", cap1, sentq1.pop_front());
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) step();

        // Directed pair accepted ahead of the first load, then two frames (second underruns).
        l32 = 32'hA5A5_0001; r32 = 32'h8000_00FF;
        l16 = 16'h8001;      r16 = 16'h7FFE;
        vld = 1'b1; rst = 1'b0;
        step();
        vld = 1'b0;
        repeat (130*2*D) step();

        // Backpressure: valid held, pattern advances only when the model says it was taken.
        vld = 1'b1;
        l32 = 32'h1000_0000; r32 = 32'h2000_0000; l16 = 16'h1000; r16 = 16'h2000;
        repeat (4*128*D) begin
            step();
            if (acc_last) begin
                l32 = l32 + 1; r32 = r32 + 1; l16 = l16 + 1; r16 = r16 + 1;
            end
        end

        // Random valid and data.
        repeat (3*128*D) begin
            vld = ($urandom % 4) == 0;
            l32 = $urandom; r32 = $urandom;
            l16 = 16'($urandom); r16 = 16'($urandom);
            step();
        end

        // Reset at bit position 40 with the buffer full.
        vld = 1'b1;
        l32 = $urandom; r32 = $urandom; l16 = 16'($urandom); r16 = 16'($urandom);
        reached = 0;
        for (int n = 0; n < 2000 && !reached; n++) begin
            step();
            reached = mfull && (t % (2*D) == 0) && ((t / (2*D)) % 64 == 40);
        end
        chk("midreset_reach", 64'(reached), 64'd1);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0; vld = 1'b0;
        repeat (130*2*D) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
